// File: rtl/addsub_accum_pkg.sv
// Shared definitions for the addsub_accum streaming accumulator.
//   WIDTH_DEF : default operand / accumulator width (matches add_sub)
//   OP_ADD / OP_SUB : encoding of the per-beat operation select
//   state_t   : accumulator FSM state encoding
package addsub_accum_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_accum_add_sub.sv
// add_sub: combinational two's-complement adder/subtractor core.
//   a, b : operands (WIDTH)
//   sel  : OP_ADD -> s = a + b, OP_SUB -> s = a - b
//   s    : result modulo 2^WIDTH
//   cout : carry out (for subtract, 1 means no borrow)
//   v    : signed overflow
module add_sub
    import addsub_accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtraction is a + ~b + 1; the +1 enters as the carry-in.
    assign b_eff = (sel == OP_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (sel == OP_SUB)};
    assign s     = sum[WIDTH-1:0];
    assign cout  = sum[WIDTH];
    // Overflow when both effective operands share a sign the result does not.
    assign v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_accum.sv
// addsub_accum: folds a burst of add/subtract operand beats into an
// accumulator through add_sub and presents the burst result on a
// valid/ready port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand beat handshake
//   in_op, in_data      : operation (0 add, 1 sub) and operand
//   in_last             : final beat of the burst
//   out_valid/out_ready : result handshake
//   out_acc             : final accumulator
//   out_ovf             : sticky signed overflow across the burst
//   out_carry           : carry of the last beat (sub: 1 = no borrow)
//   out_count           : beats accepted, saturating at all-ones
module addsub_accum
    import addsub_accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_ovf,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg;
    logic             ovf_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] count_reg;
    logic             in_ready_reg;

    logic [WIDTH-1:0] sum_s;
    logic             sum_cout;
    logic             sum_v;
    logic             beat;
    logic             result_ack;

    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .a    (acc_reg),
        .b    (in_data),
        .sel  (in_op),
        .s    (sum_s),
        .cout (sum_cout),
        .v    (sum_v)
    );

    assign beat       = in_valid && in_ready_reg;
    assign result_ack = (state_reg == ST_DONE) && out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ACCUM: begin
                if (beat) begin
                    state_next = in_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            ovf_reg      <= 1'b0;
            carry_reg    <= 1'b0;
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            // Registered so in_ready stays low through reset and has no
            // combinational path from any input.
            in_ready_reg <= (state_next != ST_DONE);
            if (beat) begin
                acc_reg   <= sum_s;
                ovf_reg   <= ovf_reg | sum_v;
                carry_reg <= sum_cout;
                if (count_reg != {CNT_W{1'b1}}) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end else if (result_ack) begin
                // Carry is left as-is; it is rewritten by the next burst's beats.
                acc_reg   <= '0;
                ovf_reg   <= 1'b0;
                count_reg <= '0;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == ST_DONE);
    assign out_acc   = acc_reg;
    assign out_ovf   = ovf_reg;
    assign out_carry = carry_reg;
    assign out_count = count_reg;

endmodule

// File: tb/tb_addsub_accum.sv
`timescale 1ns/1ps
module tb_addsub_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_acc;
    logic        out_ovf;
    logic        out_carry;
    logic [7:0]  out_count;

    int checks;
    int failures;

    bit          q_op[$];
    logic [15:0] q_data[$];

    logic [15:0] exp_acc;
    bit          exp_ovf;
    bit          exp_carry;
    int          exp_cnt;

    addsub_accum #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic over the queued beats.
    task automatic model_burst();
        int a, d, sa, sd, r;
        a = 0;
        exp_ovf = 0;
        exp_carry = 0;
        for (int i = 0; i < q_op.size(); i++) begin
            d  = int'(q_data[i]);
            sa = (a > 32767) ? a - 65536 : a;
            sd = (d > 32767) ? d - 65536 : d;
            if (!q_op[i]) begin
                r = sa + sd;
                exp_carry = ((a + d) > 65535);
                a = (a + d) & 'hFFFF;
            end else begin
                r = sa - sd;
                exp_carry = (a >= d);
                a = (a - d) & 'hFFFF;
            end
            if (r > 32767 || r < -32768) exp_ovf = 1;
        end
        exp_acc = a[15:0];
        exp_cnt = (q_op.size() > 255) ? 255 : q_op.size();
    endtask

    // Drives queued beats one per cycle; stops early at abort_at by
    // asserting reset instead of driving that beat. Returns at posedge+1.
    task automatic drive_burst(input int abort_at);
        int n, t;
        n = q_op.size();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                in_valid = 0;
                rst_n = 0;
                return;
            end
            in_valid = 1;
            in_op    = q_op[i];
            in_data  = q_data[i];
            in_last  = (i == n - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready === 1'b1) break;
                t++;
                if (t > 20) begin
                    checks++; failures++;
                    $display("FAIL beat_accept beat=%0d in_ready=%b required=1", i, in_ready);
                    in_valid = 0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    // Called right after the last beat is accepted: checks latency, holds
    // the result for 'hold' cycles, then completes the handshake.
    task automatic check_result(input string name, input int hold);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency out_valid=%b required=1", name, out_valid);
        end
        for (int c = 0; c <= hold; c++) begin
            checks++;
            if (out_acc !== exp_acc || out_ovf !== exp_ovf || out_carry !== exp_carry ||
                out_count !== 8'(exp_cnt) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s_result cyc=%0d acc=%h ovf=%b carry=%b count=%0d rdy=%b vld=%b required acc=%h ovf=%b carry=%b count=%0d rdy=0 vld=1",
                         name, c, out_acc, out_ovf, out_carry, out_count, in_ready, out_valid,
                         exp_acc, exp_ovf, exp_carry, exp_cnt);
            end
            if (c < hold) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 16'h0 || out_count !== 8'h0 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_ack vld=%b rdy=%b acc=%h count=%0d ovf=%b required vld=0 rdy=1 acc=0000 count=0 ovf=0",
                     name, out_valid, in_ready, out_acc, out_count, out_ovf);
        end
        $display("burst %s beats=%0d acc=%h ovf=%b carry=%b count=%0d", name, q_op.size(), exp_acc, exp_ovf, exp_carry, exp_cnt);
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_acc !== 16'h0 || out_ovf !== 1'b0 ||
            out_carry !== 1'b0 || out_count !== 8'h0) begin
            failures++;
            $display("FAIL %s vld=%b rdy=%b acc=%h ovf=%b carry=%b count=%0d required all 0",
                     name, out_valid, in_ready, out_acc, out_ovf, out_carry, out_count);
        end
    endtask

    task automatic release_reset(input string name);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_release rdy=%b vld=%b required rdy=1 vld=0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        check_cleared("reset_held");
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_held_clk");
        release_reset("reset");
        // Reset while a result is waiting in DONE.
        q_op = {1'b0}; q_data = {16'h1234};
        drive_burst(-1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_done_setup out_valid=%b required=1", out_valid);
        end
        rst_n = 0;
        #1;
        check_cleared("reset_in_done");
        release_reset("reset_in_done");
        $display("test_reset done");
    endtask

    task automatic test_add_burst();
        q_op = {1'b0, 1'b0, 1'b0};
        q_data = {16'h0001, 16'h0101, 16'h0202};
        model_burst();
        drive_burst(-1);
        checks++;
        if (out_acc !== 16'h0304) begin
            failures++;
            $display("FAIL add_burst_const acc=%h required=0304", out_acc);
        end
        check_result("add_burst", 0);
    endtask

    task automatic test_sub_single();
        q_op = {1'b1};
        q_data = {16'h0101};
        model_burst();
        drive_burst(-1);
        checks++;
        if (out_acc !== 16'hFEFF || out_carry !== 1'b0 || out_count !== 8'd1) begin
            failures++;
            $display("FAIL sub_single_const acc=%h carry=%b count=%0d required acc=feff carry=0 count=1",
                     out_acc, out_carry, out_count);
        end
        check_result("sub_single", 0);
    endtask

    task automatic test_sticky_ovf();
        q_op = {1'b0, 1'b0, 1'b1};
        q_data = {16'h7FFF, 16'h0001, 16'h0001};
        model_burst();
        drive_burst(-1);
        checks++;
        if (out_acc !== 16'h7FFF || out_ovf !== 1'b1) begin
            failures++;
            $display("FAIL sticky_ovf_const acc=%h ovf=%b required acc=7fff ovf=1", out_acc, out_ovf);
        end
        check_result("sticky_ovf", 0);
    endtask

    task automatic test_backpressure();
        q_op = {1'b1, 1'b0};
        q_data = {16'h0010, 16'h0003};
        model_burst();
        drive_burst(-1);
        check_result("backpressure", 5);
        q_op = {1'b0};
        q_data = {16'h0005};
        model_burst();
        drive_burst(-1);
        checks++;
        if (out_acc !== 16'h0005) begin
            failures++;
            $display("FAIL backpressure_next acc=%h required=0005", out_acc);
        end
        check_result("backpressure_next", 0);
    endtask

    task automatic test_count_sat();
        q_op.delete(); q_data.delete();
        for (int i = 0; i < 300; i++) begin
            q_op.push_back(1'b0);
            q_data.push_back(16'h0001);
        end
        model_burst();
        drive_burst(-1);
        checks++;
        if (out_acc !== 16'h012C || out_count !== 8'd255) begin
            failures++;
            $display("FAIL count_sat_const acc=%h count=%0d required acc=012c count=255", out_acc, out_count);
        end
        check_result("count_sat", 1);
    endtask

    task automatic test_mid_reset();
        int seen;
        drive_burst(149);
        #1;
        check_cleared("mid_reset");
        release_reset("mid_reset");
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset_no_valid valid_cycles=%0d required=0", seen);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        int len;
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(1, 12);
            q_op.delete(); q_data.delete();
            for (int i = 0; i < len; i++) begin
                q_op.push_back(1'($urandom_range(0, 1)));
                case ($urandom_range(0, 3))
                    0: q_data.push_back(16'h7FFF + 16'($urandom_range(0, 2)));
                    1: q_data.push_back(16'($urandom_range(0, 15)));
                    default: q_data.push_back(16'($urandom));
                endcase
            end
            model_burst();
            drive_burst(-1);
            check_result($sformatf("random%0d", b), $urandom_range(0, 3));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 0;
        in_valid  = 0;
        in_op     = 0;
        in_data   = 0;
        in_last   = 0;
        out_ready = 0;
        test_reset();
        test_add_burst();
        test_sub_single();
        test_sticky_ovf();
        test_backpressure();
        test_count_sat();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
